// File: rtl/elev_pkg.sv
// Shared elevator definitions: car state codes, floor type and small constant helpers.
package elev_pkg;

  localparam int NUM_FLOORS_MAX = 5;
  localparam int FLOOR_W        = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOOR = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } car_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Cycle counter with clear and enable; done pulses on the last cycle of a CYCLES-long period.
module elev_timer #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  input  logic run,
  output logic done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] count;

  // Clear takes priority, so a hold/reopen on the terminal cycle restarts the dwell.
  assign done = enable && run && !clear && (count == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (enable) begin
      if (clear)
        count <= '0;
      else if (run)
        count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/car_motion_ctrl.sv
// Elevator car sequencer: IDLE/DOOR/UP/DOWN with per-floor travel and door dwell timers.
// Optional macro DOOR_HOLD_EN: door_hold and a current-floor request restart the door dwell.
module car_motion_ctrl
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS   = 5,
  parameter int FLOOR_CYCLES = 50000000,
  parameter int DOOR_CYCLES  = 100000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [2:0] dest,
  input  logic [4:0] pending,
  input  logic       door_hold,
  output logic [1:0] state,
  output logic [2:0] location,
  output logic       door_open,
  output logic       arrive
);

  localparam int     CNT_W     = $clog2(max2(FLOOR_CYCLES, DOOR_CYCLES));
  localparam floor_t TOP_FLOOR = floor_t'(NUM_FLOORS);
  localparam floor_t BOT_FLOOR = floor_t'(1);

  car_state_e st;
  floor_t     eff_dest;
  floor_t     next_loc;
  logic       dest_valid;
  logic       here_req;
  logic       next_req;
  logic       moving;
  logic       travel_done;
  logic       door_done;
  logic       door_clr;

  assign state      = st;
  assign moving     = (st == ST_UP) || (st == ST_DOWN);
  assign dest_valid = (dest != 3'd0) && (dest <= TOP_FLOOR);
  assign eff_dest   = dest_valid ? dest : location;
  assign here_req   = pending[location - 3'd1];

  // Clamped neighbour floor; location can never step outside 1..NUM_FLOORS.
  always_comb begin
    next_loc = location;
    if (st == ST_UP && location < TOP_FLOOR)
      next_loc = location + 3'd1;
    else if (st == ST_DOWN && location > BOT_FLOOR)
      next_loc = location - 3'd1;
  end

  assign next_req = pending[next_loc - 3'd1];

`ifdef DOOR_HOLD_EN
  assign door_clr = (st != ST_DOOR) || door_hold || here_req;
`else
  logic door_hold_unused;
  assign door_hold_unused = door_hold;
  assign door_clr = (st != ST_DOOR);
`endif

  elev_timer #(.WIDTH(CNT_W), .CYCLES(FLOOR_CYCLES)) u_travel (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .clear  (!moving),
    .run    (moving),
    .done   (travel_done)
  );

  elev_timer #(.WIDTH(CNT_W), .CYCLES(DOOR_CYCLES)) u_door (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .clear  (door_clr),
    .run    (st == ST_DOOR),
    .done   (door_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= ST_IDLE;
      location  <= BOT_FLOOR;
      door_open <= 1'b0;
      arrive    <= 1'b0;
    end else begin
      arrive <= 1'b0;
      if (enable) begin
        case (st)
          ST_IDLE: begin
            if (here_req) begin
              st        <= ST_DOOR;
              door_open <= 1'b1;
            end else if (eff_dest > location) begin
              st <= ST_UP;
            end else if (eff_dest < location) begin
              st <= ST_DOWN;
            end
          end
          ST_DOOR: begin
            if (door_done) begin
              st        <= ST_IDLE;
              door_open <= 1'b0;
            end
          end
          default: begin
            if (travel_done) begin
              location <= next_loc;
              arrive   <= 1'b1;
              if (next_loc == eff_dest || next_req) begin
                st        <= ST_DOOR;
                door_open <= 1'b1;
              end else if (st == ST_UP && eff_dest > next_loc && next_loc < TOP_FLOOR) begin
                st <= ST_UP;
              end else if (st == ST_DOWN && eff_dest < next_loc && next_loc > BOT_FLOOR) begin
                st <= ST_DOWN;
              end else begin
                // Destination moved behind the car, or end of shaft: re-decide from IDLE.
                st <= ST_IDLE;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl with an arrival scoreboard (FLOOR_CYCLES=4, DOOR_CYCLES=6).
module tb_car_motion_ctrl;
  import elev_pkg::*;

  localparam int FC = 4;
  localparam int DC = 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] dest = 3'd1;
  logic [4:0] pending = 5'd0;
  logic       door_hold = 1'b0;
  logic [1:0] state;
  logic [2:0] location;
  logic       door_open;
  logic       arrive;

  car_motion_ctrl #(.NUM_FLOORS(5), .FLOOR_CYCLES(FC), .DOOR_CYCLES(DC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .dest      (dest),
    .pending   (pending),
    .door_hold (door_hold),
    .state     (state),
    .location  (location),
    .door_open (door_open),
    .arrive    (arrive)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] loc;
    logic [1:0] st;
    int         gap;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_arr(input logic [2:0] l, input logic [1:0] s, input int g);
    exp_t e;
    e.loc = l;
    e.st  = s;
    e.gap = g;
    sbq.push_back(e);
  endtask

  // Waits (bounded) for the next arrive pulse and compares it against the scoreboard head.
  task automatic wait_arrive(input string tag);
    exp_t e;
    int   n;
    n = 0;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sbq.pop_front();
    do begin
      @(negedge clk);
      n++;
    end while (!arrive && n < 40);
    chk({tag, " arrive"}, arrive, 1);
    chk({tag, " gap"}, n, e.gap);
    chk({tag, " loc"}, location, e.loc);
    chk({tag, " state"}, state, e.st);
  endtask

  initial begin
    int bad;
    int seen;

    // Reset values
    step(2);
    chk("rst state", state, ST_IDLE);
    chk("rst loc", location, 1);
    chk("rst door_open", door_open, 0);
    chk("rst arrive", arrive, 0);
    resetn = 1'b1;
    enable = 1'b1;

    // Idle at floor 1 for 20 cycles
    bad = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (state !== ST_IDLE || location !== 3'd1) bad++;
      if (arrive) seen++;
    end
    chk("idle held", bad, 0);
    chk("idle arrive", seen, 0);

    // Invalid destination means no motion
    dest = 3'd7;
    step(8);
    chk("invalid dest state", state, ST_IDLE);
    chk("invalid dest loc", location, 1);

    // 1 -> 4
    dest = 3'd4;
    expect_arr(3'd2, ST_UP, 5);
    expect_arr(3'd3, ST_UP, FC);
    expect_arr(3'd4, ST_DOOR, FC);
    wait_arrive("up1_2");
    wait_arrive("up2_3");
    wait_arrive("up3_4");
    chk("door_open at 4", door_open, 1);
    step(1);
    chk("arrive one cycle", arrive, 0);
    step(DC - 2);
    chk("door dwell at 4", state, ST_DOOR);
    step(1);
    chk("door closed at 4", state, ST_IDLE);
    chk("door_open low at 4", door_open, 0);

    // 4 -> 1
    dest = 3'd1;
    expect_arr(3'd3, ST_DOWN, 5);
    expect_arr(3'd2, ST_DOWN, FC);
    expect_arr(3'd1, ST_DOOR, FC);
    wait_arrive("dn4_3");
    wait_arrive("dn3_2");
    wait_arrive("dn2_1");
    step(DC);
    chk("idle at 1", state, ST_IDLE);

    // 1 -> 5 with an intermediate stop requested at floor 3
    dest = 3'd5;
    expect_arr(3'd2, ST_UP, 5);
    wait_arrive("mid1_2");
    pending = 5'b00100;
    expect_arr(3'd3, ST_DOOR, FC);
    wait_arrive("mid2_3");
    pending = 5'b00000;
    step(DC);
    chk("mid idle at 3", state, ST_IDLE);
    expect_arr(3'd4, ST_UP, 5);
    expect_arr(3'd5, ST_DOOR, FC);
    wait_arrive("mid3_4");
    wait_arrive("mid4_5");
    step(DC);
    chk("idle at 5", state, ST_IDLE);

    // 5 -> 1, then 1 -> 3 reversed mid-floor to 1
    dest = 3'd1;
    expect_arr(3'd4, ST_DOWN, 5);
    expect_arr(3'd3, ST_DOWN, FC);
    expect_arr(3'd2, ST_DOWN, FC);
    expect_arr(3'd1, ST_DOOR, FC);
    wait_arrive("dn5_4");
    wait_arrive("dn4_3b");
    wait_arrive("dn3_2b");
    wait_arrive("dn2_1b");
    step(DC);
    dest = 3'd3;
    step(2);
    chk("rev moving up", state, ST_UP);
    dest = 3'd1;
    expect_arr(3'd2, ST_IDLE, 3);
    expect_arr(3'd1, ST_DOOR, 5);
    wait_arrive("rev1_2");
    wait_arrive("rev2_1");
    step(DC);
    chk("rev idle at 1", state, ST_IDLE);

    // Freeze mid-floor
    dest = 3'd2;
    step(2);
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (state !== ST_UP || location !== 3'd1 || arrive !== 1'b0) bad++;
    end
    chk("frozen", bad, 0);
    enable = 1'b1;
    expect_arr(3'd2, ST_DOOR, 3);
    wait_arrive("frz1_2");
    step(DC);
    chk("frz idle at 2", state, ST_IDLE);

    // Door hold at floor 2
    pending = 5'b00010;
    step(1);
    chk("hold door opened", state, ST_DOOR);
    pending = 5'b00000;
    door_hold = 1'b1;
    step(DC - 1);
    chk("hold dwell early", state, ST_DOOR);
    step(1);
`ifdef DOOR_HOLD_EN
    chk("hold at fixed dwell", state, ST_DOOR);
`else
    chk("hold at fixed dwell", state, ST_IDLE);
`endif
    step(4);
    door_hold = 1'b0;
    step(DC - 1);
`ifdef DOOR_HOLD_EN
    chk("hold after release", state, ST_DOOR);
`else
    chk("hold after release", state, ST_IDLE);
`endif
    step(1);
    chk("hold closed", state, ST_IDLE);
    chk("hold loc", location, 2);

    // Async reset mid-trip
    dest = 3'd4;
    step(3);
    chk("pre-reset moving", state, ST_UP);
    #2 resetn = 1'b0;
    #1;
    chk("async rst state", state, ST_IDLE);
    chk("async rst loc", location, 1);
    chk("async rst door_open", door_open, 0);
    step(2);
    resetn = 1'b1;
    step(2);

    chk("scoreboard drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
